// File: rtl/fetch_unit_if.sv
// Instruction-bus and decode-side handshake signals of the fetch stage.
// The master modport is the fetch unit; the slave modport is the bus plus decode.
interface fetch_unit_if #(
   parameter int ILEN = 32
);
   logic            ireq_valid;
   logic [63:0]     ireq_addr;
   logic            iresp_addr_ok;
   logic            iresp_data_ok;
   logic [ILEN-1:0] iresp_data;
   logic            out_valid;
   logic            out_ready;
   logic [63:0]     out_pc;
   logic [ILEN-1:0] out_instr;
   logic            out_misalign;

   modport master (
      output ireq_valid, ireq_addr,
      input  iresp_addr_ok, iresp_data_ok, iresp_data,
      output out_valid, out_pc, out_instr, out_misalign,
      input  out_ready
   );

   modport slave (
      input  ireq_valid, ireq_addr,
      output iresp_addr_ok, iresp_data_ok, iresp_data,
      input  out_valid, out_pc, out_instr, out_misalign,
      output out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Non-pipelined fetch stage: one bus request per PC, {pc, instr} handed to decode
// through an output register backed by a one-entry skid buffer.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int          ILEN     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] pc,
   input  logic        flush,
   output logic        fetch_stall,
   fetch_unit_if.master bus
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DELIVER, HOLD} state_t;

   state_t          state;
   logic            discard;
   logic [63:0]     skid_pc;
   logic [ILEN-1:0] skid_instr;
   logic            skid_misalign;

   logic rsp_now;
   logic out_free;
   logic bus_take;
   logic load_bus;
   logic load_skid;
   logic load;

   // A response counts in WAIT, or in REQ when accepted and answered together.
   always_comb begin
      rsp_now     = bus.iresp_data_ok &&
                    ((state == WAIT) || ((state == REQ) && bus.iresp_addr_ok));
      out_free    = !bus.out_valid || bus.out_ready;
      bus_take    = rsp_now && !discard && !flush;
      load_bus    = bus_take && out_free;
      load_skid   = !flush && (((state == DELIVER) && out_free) ||
                               ((state == HOLD) && bus.out_ready));
      load        = load_bus || load_skid;
      fetch_stall = !reset || !(flush || load);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         discard          <= 1'b0;
         skid_pc          <= RESET_PC;
         skid_instr       <= '0;
         skid_misalign    <= 1'b0;
         bus.ireq_valid   <= 1'b0;
         bus.ireq_addr    <= RESET_PC;
         bus.out_valid    <= 1'b0;
         bus.out_pc       <= RESET_PC;
         bus.out_instr    <= '0;
         bus.out_misalign <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!flush) begin
                  if (pc[1:0] != 2'b00) begin
                     skid_pc       <= pc;
                     skid_instr    <= '0;
                     skid_misalign <= 1'b1;
                     state         <= DELIVER;
                  end else begin
                     bus.ireq_valid <= 1'b1;
                     bus.ireq_addr  <= pc;
                     state          <= REQ;
                  end
               end
            end
            REQ, WAIT: begin
               if ((state == REQ) && bus.iresp_addr_ok) begin
                  bus.ireq_valid <= 1'b0;
               end
               if (rsp_now) begin
                  discard <= 1'b0;
                  if (!bus_take || out_free) begin
                     state <= IDLE;
                  end else begin
                     skid_pc       <= bus.ireq_addr;
                     skid_instr    <= bus.iresp_data;
                     skid_misalign <= 1'b0;
                     state         <= DELIVER;
                  end
               end else begin
                  // The request cannot be withdrawn, so a flush only marks its data as stale.
                  if (flush) begin
                     discard <= 1'b1;
                  end
                  if ((state == REQ) && bus.iresp_addr_ok) begin
                     state <= WAIT;
                  end
               end
            end
            DELIVER: begin
               if (flush || out_free) begin
                  state <= IDLE;
               end else begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (flush || bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (flush) begin
            bus.out_valid <= 1'b0;
         end else if (load_bus) begin
            bus.out_valid    <= 1'b1;
            bus.out_pc       <= bus.ireq_addr;
            bus.out_instr    <= bus.iresp_data;
            bus.out_misalign <= 1'b0;
         end else if (load_skid) begin
            bus.out_valid    <= 1'b1;
            bus.out_pc       <= skid_pc;
            bus.out_instr    <= skid_instr;
            bus.out_misalign <= skid_misalign;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues one instruction-bus request per PC, and waits for the 32-bit instruction.
- Delivers {pc, instr} to decode through a valid/ready output register with a one-entry skid buffer.
- Drives fetch_stall back to the PC register so the PC advances only when an instruction has been handed off.

Parameters:
RESET_PC, 64'h8000_0000, value of out_pc and ireq_addr while in reset
ILEN, 32, instruction width in bits

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
pc  input  64  current PC from the PC register
flush  input  1  redirect/jump; discard in-flight and buffered fetches
fetch_stall  output  1  1 = PC register must hold pc
ireq_valid  output  1  bus request valid
ireq_addr  output  64  bus request address
iresp_addr_ok  input  1  request accepted this cycle
iresp_data_ok  input  1  response data valid this cycle
iresp_data  input  32  instruction word
out_valid  output  1  decode-side valid
out_ready  input  1  decode can accept
out_pc  output  64  PC of out_instr
out_instr  output  32  instruction
out_misalign  output  1  pc[1:0] != 0; out_instr = 0

Behaviour:
- Reset (reset==0, asynchronous):
  - state = IDLE; ireq_valid = 0; ireq_addr = RESET_PC.
  - out_valid = 0; out_pc = RESET_PC; out_instr = 0; out_misalign = 0.
  - Skid buffer empty; discard flag cleared; fetch_stall = 1.
- States:
  - IDLE: pc aligned and no flush -> register ireq_valid = 1, ireq_addr = pc; go to REQ. Misaligned pc -> go directly to DELIVER with instr = 0 and misalign = 1; no bus request is issued.
  - REQ: ireq_valid and ireq_addr are held stable until iresp_addr_ok (AXI-like rule; never withdrawn). On addr_ok: ireq_valid <= 0 and go to WAIT. addr_ok and data_ok in the same cycle is legal and is handled as WAIT + data_ok.
  - WAIT: on data_ok, capture iresp_data and go to DELIVER (same-cycle delivery if possible).
  - DELIVER: if out_valid == 0 or out_ready == 1, load the output register and go to IDLE. Otherwise park the instruction in the skid buffer and go to HOLD.
  - HOLD: when out_ready == 1, move the skid buffer into the output register and go to IDLE.
- fetch_stall:
  - 0 only in the cycle an instruction is loaded into the output register, and in a flush cycle.
  - 1 otherwise, including reset.
  - The PC therefore advances exactly once per delivered instruction.
- Output register:
  - out_valid clears when out_ready == 1 and nothing new is loaded.
  - Data stays stable while out_valid == 1 and out_ready == 0.
- Latency: with an ideal bus (addr_ok in the cycle after issue, data_ok one cycle later), pc is sampled in IDLE and out_valid rises 3 cycles later. Throughput is 1 instruction per 3 cycles (non-pipelined, one outstanding request).
- flush:
  - Always clears out_valid and the skid buffer on the next edge.
  - IDLE / DELIVER / HOLD: go to IDLE, and the new pc is issued next cycle.
  - REQ: the request stays asserted until addr_ok, then the discard flag is set.
  - WAIT, or REQ with discard set: the next data_ok is dropped, then go to IDLE.
  - flush concurrent with data_ok: that data is dropped.
  - flush has priority over out_ready.
- At most one outstanding request ever. A data_ok arriving in IDLE/DELIVER/HOLD is ignored.
- Reset asserted mid-transaction: everything returns to reset values immediately. Stale bus responses after reset release are not expected; the bus is reset together with this block.

Test Plan:
- Reset release, pc = 0x8000_0000, ideal bus returning 0x00000013 -> ireq_addr = 0x8000_0000; out_valid = 1 with out_pc = 0x8000_0000, out_instr = 0x00000013 three cycles after IDLE; fetch_stall low exactly 1 cycle.
- Bus holds addr_ok low 4 cycles -> ireq_valid and ireq_addr (0x8000_0004) stable for all 5 cycles; fetch_stall = 1 throughout; no duplicate request.
- out_ready = 0 for 6 cycles after delivery of 0x8000_0000, next fetch completes meanwhile -> second instruction held in HOLD; out_pc/out_instr unchanged; fetch_stall = 1; when ready rises, 0x8000_0004 appears next cycle.
- flush in WAIT while pc changes to 0x8000_0100 -> the pending data_ok word is dropped, out_valid stays 0, next ireq_addr = 0x8000_0100.
- pc = 0x8000_0002 -> no ireq_valid; out_valid = 1, out_misalign = 1, out_instr = 0.
- reset driven low during REQ -> ireq_valid = 0 and out_valid = 0 immediately, without waiting for a clock edge.
